// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: collects mailbox requests, waits for bus idle, grants the
// lowest-identifier pending mailbox to the bit transmitter and resolves the result.
module can_tx_scheduler #(
    parameter int NUM_MB       = 4,
    parameter int SEL_W        = 2,
    parameter int CLKS_PER_BIT = 10,
    parameter int IDLE_BITS    = 11,
    parameter int RETRY_MAX    = 3
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_MB-1:0]    i_Req,
    input  logic [NUM_MB*11-1:0] i_Id,
    input  logic                 i_Rx_Serial,
    output logic                 o_Tx_Valid,
    input  logic                 i_Tx_Ready,
    output logic [SEL_W-1:0]     o_Tx_Sel,
    output logic [10:0]          o_Tx_Id,
    input  logic                 i_Tx_Done,
    input  logic                 i_Tx_Lost,
    input  logic                 i_Tx_Err,
    output logic [NUM_MB-1:0]    o_Pending,
    output logic [NUM_MB-1:0]    o_Done,
    output logic [NUM_MB-1:0]    o_Abort,
    output logic                 o_Busy
);

    localparam int             IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int             CNT_W      = $clog2(IDLE_LIMIT + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_LIMIT);
    localparam logic [3:0]     RETRY_LIM  = 4'(RETRY_MAX);

    typedef enum logic [1:0] {
        S_IDLE_WAIT,
        S_SELECT,
        S_OFFER,
        S_ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_sync_q, rx_sync_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [NUM_MB-1:0]  pending_q, pending_d;
    logic [3:0]         retry_q [NUM_MB];
    logic [3:0]         retry_d [NUM_MB];
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [10:0]        id_q, id_d;
    logic [NUM_MB-1:0]  done_q, done_d;
    logic [NUM_MB-1:0]  abort_q, abort_d;

    logic [10:0]        mb_id [NUM_MB];
    logic               best_found;
    logic [SEL_W-1:0]   best_sel;
    logic [10:0]        best_id;
    logic               bus_idle;
    logic [3:0]         retry_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MB; gi++) begin : g_id
            assign mb_id[gi] = i_Id[gi*11 +: 11];
        end
    endgenerate

    // Strict less-than keeps the lowest index on identifier ties.
    always_comb begin
        best_found = 1'b0;
        best_sel   = '0;
        best_id    = '1;
        for (int k = 0; k < NUM_MB; k++) begin
            if (pending_q[k] && (!best_found || (mb_id[k] < best_id))) begin
                best_found = 1'b1;
                best_sel   = SEL_W'(k);
                best_id    = mb_id[k];
            end
        end
    end

    assign bus_idle = (idle_cnt_q == IDLE_MAX);

    always_comb begin
        rx_meta_d  = i_Rx_Serial;
        rx_sync_d  = rx_meta_q;
        state_d    = state_q;
        pending_d  = pending_q;
        retry_d    = retry_q;
        sel_d      = sel_q;
        id_d       = id_q;
        done_d     = '0;
        abort_d    = '0;
        retry_next = retry_q[sel_q] + 4'd1;

        if (!rx_sync_q) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        case (state_q)
            S_IDLE_WAIT: begin
                if (bus_idle && (|pending_q)) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                sel_d   = best_sel;
                id_d    = best_id;
                state_d = S_OFFER;
            end
            S_OFFER: begin
                if (i_Tx_Ready) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (i_Tx_Done || i_Tx_Err || i_Tx_Lost) begin
                    state_d    = S_IDLE_WAIT;
                    idle_cnt_d = '0;
                end
                if (i_Tx_Done) begin
                    pending_d[sel_q] = 1'b0;
                    retry_d[sel_q]   = '0;
                    done_d[sel_q]    = 1'b1;
                end else if (i_Tx_Err) begin
                    if (retry_next == RETRY_LIM) begin
                        pending_d[sel_q] = 1'b0;
                        retry_d[sel_q]   = '0;
                        abort_d[sel_q]   = 1'b1;
                    end else begin
                        retry_d[sel_q] = retry_next;
                    end
                end
            end
            default: state_d = S_IDLE_WAIT;
        endcase

        // A new request overrides a same-cycle completion and restarts its retry budget.
        for (int k = 0; k < NUM_MB; k++) begin
            if (i_Req[k]) begin
                pending_d[k] = 1'b1;
                retry_d[k]   = '0;
            end
        end
    end

    // Synchronizer resets to dominant so the bus must prove idle after reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= S_IDLE_WAIT;
            rx_meta_q  <= 1'b0;
            rx_sync_q  <= 1'b0;
            idle_cnt_q <= '0;
            pending_q  <= '0;
            retry_q    <= '{default: '0};
            sel_q      <= '0;
            id_q       <= '0;
            done_q     <= '0;
            abort_q    <= '0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            idle_cnt_q <= idle_cnt_d;
            pending_q  <= pending_d;
            retry_q    <= retry_d;
            sel_q      <= sel_d;
            id_q       <= id_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign o_Tx_Valid = (state_q == S_OFFER);
    assign o_Busy     = (state_q == S_OFFER) || (state_q == S_ACTIVE);
    assign o_Tx_Sel   = sel_q;
    assign o_Tx_Id    = id_q;
    assign o_Pending  = pending_q;
    assign o_Done     = done_q;
    assign o_Abort    = abort_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed testbench for can_tx_scheduler: idle timing, priority, retry and
// coincidence behaviour with hand-computed expectations.
module tb_can_tx_scheduler;

    localparam int NUM_MB = 4;
    localparam int SEL_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_MB-1:0]    req;
    logic [NUM_MB*11-1:0] id_vec;
    logic                 rx;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [SEL_W-1:0]     tx_sel;
    logic [10:0]          tx_id;
    logic                 tx_done;
    logic                 tx_lost;
    logic                 tx_err;
    logic [NUM_MB-1:0]    pending;
    logic [NUM_MB-1:0]    done_p;
    logic [NUM_MB-1:0]    abort_p;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    can_tx_scheduler #(
        .NUM_MB(NUM_MB), .SEL_W(SEL_W), .CLKS_PER_BIT(10), .IDLE_BITS(11), .RETRY_MAX(3)
    ) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Id(id_vec),
        .i_Rx_Serial(rx), .o_Tx_Valid(tx_valid), .i_Tx_Ready(tx_ready),
        .o_Tx_Sel(tx_sel), .o_Tx_Id(tx_id), .i_Tx_Done(tx_done),
        .i_Tx_Lost(tx_lost), .i_Tx_Err(tx_err), .o_Pending(pending),
        .o_Done(done_p), .o_Abort(abort_p), .o_Busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; tx_ready = 1'b0; tx_done = 1'b0;
        tx_lost = 1'b0; tx_err = 1'b0; rx = 1'b1; id_vec = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic send_req(input logic [NUM_MB-1:0] mask);
        req = mask;
        tick;
        req = '0;
    endtask

    task automatic wait_valid(input int bound, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (n < bound && !found) begin
            tick;
            n++;
            if (tx_valid) found = 1'b1;
        end
        $display("offer after %0d cycles found=%0d sel=%0d id=%h", n, found, tx_sel, tx_id);
    endtask

    task automatic accept;
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
    endtask

    task automatic result(input logic d, input logic e, input logic l);
        tx_done = d; tx_err = e; tx_lost = l;
        tick;
        tx_done = 1'b0; tx_err = 1'b0; tx_lost = 1'b0;
        $display("result done=%0d err=%0d lost=%0d -> o_Done=%b o_Abort=%b pending=%b",
                 d, e, l, done_p, abort_p, pending);
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({tx_valid, busy, done_p, abort_p, pending, tx_sel, tx_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b done=%b abort=%b pend=%b sel=%0d id=%h, want all 0",
                     tx_valid, busy, done_p, abort_p, pending, tx_sel, tx_id);
        end
    endtask

    task automatic test_single;
        int n; bit found;
        do_reset;
        id_vec[0 +: 11] = 11'h123;
        send_req(4'b0001);
        wait_valid(300, n, found);
        checks++;
        if (!found || n !== 113) begin
            errors++;
            $display("FAIL single_latency: got found=%0d cycles=%0d, want 113", found, n);
        end
        checks++;
        if (tx_sel !== 2'd0 || tx_id !== 11'h123 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got sel=%0d id=%h busy=%b, want sel=0 id=123 busy=1", tx_sel, tx_id, busy);
        end
        accept;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_active: got valid=%b busy=%b, want 0 1", tx_valid, busy);
        end
        result(1'b1, 1'b0, 1'b0);
        checks++;
        if (done_p !== 4'b0001 || pending !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%b pend=%b busy=%b, want 0001 0000 0", done_p, pending, busy);
        end
        tick;
        checks++;
        if (done_p !== 4'b0000) begin
            errors++;
            $display("FAIL single_done_pulse: got done=%b, want 0000", done_p);
        end
    endtask

    task automatic test_priority;
        int n; bit found;
        do_reset;
        id_vec[11 +: 11] = 11'h200;
        id_vec[22 +: 11] = 11'h050;
        id_vec[33 +: 11] = 11'h050;
        send_req(4'b1110);
        wait_valid(300, n, found);
        checks++;
        if (!found || tx_sel !== 2'd2 || tx_id !== 11'h050) begin
            errors++;
            $display("FAIL prio_first: got found=%0d sel=%0d id=%h, want sel=2 id=050", found, tx_sel, tx_id);
        end
        accept;
        result(1'b1, 1'b0, 1'b0);
        wait_valid(300, n, found);
        checks++;
        if (!found || tx_sel !== 2'd3 || tx_id !== 11'h050) begin
            errors++;
            $display("FAIL prio_second: got found=%0d sel=%0d id=%h, want sel=3 id=050", found, tx_sel, tx_id);
        end
        accept;
        result(1'b1, 1'b0, 1'b0);
        checks++;
        if (done_p !== 4'b1000) begin
            errors++;
            $display("FAIL prio_second_done: got done=%b, want 1000", done_p);
        end
        wait_valid(300, n, found);
        checks++;
        if (!found || tx_sel !== 2'd1 || tx_id !== 11'h200) begin
            errors++;
            $display("FAIL prio_third: got found=%0d sel=%0d id=%h, want sel=1 id=200", found, tx_sel, tx_id);
        end
        accept;
        result(1'b1, 1'b0, 1'b0);
        checks++;
        if (done_p !== 4'b0010 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL prio_third_done: got done=%b pend=%b, want 0010 0000", done_p, pending);
        end
    endtask

    task automatic test_idle_gating;
        int n; bit found;
        do_reset;
        id_vec[0 +: 11] = 11'h123;
        send_req(4'b0001);
        for (int i = 0; i < 101; i++) tick;
        rx = 1'b0;
        tick;
        rx = 1'b1;
        wait_valid(300, n, found);
        checks++;
        if (!found || n !== 114) begin
            errors++;
            $display("FAIL idle_gating: got found=%0d cycles=%0d, want 114", found, n);
        end
    endtask

    task automatic test_lost;
        int n; bit found;
        do_reset;
        id_vec[0 +: 11] = 11'h123;
        send_req(4'b0001);
        wait_valid(300, n, found);
        for (int r = 0; r < 5; r++) begin
            accept;
            result(1'b0, 1'b0, 1'b1);
            checks++;
            if (abort_p !== 4'b0000 || pending !== 4'b0001 || busy !== 1'b0) begin
                errors++;
                $display("FAIL lost_%0d: got abort=%b pend=%b busy=%b, want 0000 0001 0", r, abort_p, pending, busy);
            end
            wait_valid(300, n, found);
            checks++;
            if (!found || n !== 112) begin
                errors++;
                $display("FAIL lost_reoffer_%0d: got found=%0d cycles=%0d, want 112", r, found, n);
            end
        end
        accept;
        result(1'b1, 1'b0, 1'b0);
        checks++;
        if (done_p !== 4'b0001 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL lost_then_done: got done=%b pend=%b, want 0001 0000", done_p, pending);
        end
    endtask

    task automatic test_err_retry;
        int n; bit found;
        do_reset;
        id_vec[11 +: 11] = 11'h0AA;
        send_req(4'b0010);
        wait_valid(300, n, found);
        for (int r = 0; r < 2; r++) begin
            accept;
            result(1'b0, 1'b1, 1'b0);
            checks++;
            if (abort_p !== 4'b0000 || pending !== 4'b0010) begin
                errors++;
                $display("FAIL err_%0d: got abort=%b pend=%b, want 0000 0010", r, abort_p, pending);
            end
            wait_valid(300, n, found);
            checks++;
            if (!found || n !== 112 || tx_sel !== 2'd1) begin
                errors++;
                $display("FAIL err_reoffer_%0d: got found=%0d cycles=%0d sel=%0d, want 112 sel=1", r, found, n, tx_sel);
            end
        end
        accept;
        result(1'b0, 1'b1, 1'b0);
        checks++;
        if (abort_p !== 4'b0010 || pending !== 4'b0000 || done_p !== 4'b0000) begin
            errors++;
            $display("FAIL err_abort: got abort=%b pend=%b done=%b, want 0010 0000 0000", abort_p, pending, done_p);
        end
        wait_valid(200, n, found);
        checks++;
        if (found !== 1'b0 || abort_p !== 4'b0000) begin
            errors++;
            $display("FAIL err_no_reoffer: got found=%0d abort=%b, want 0 0000", found, abort_p);
        end
    endtask

    task automatic test_coincidence;
        int n; bit found;
        do_reset;
        id_vec[0 +: 11] = 11'h123;
        send_req(4'b0001);
        wait_valid(300, n, found);
        accept;
        rst = 1'b1;
        tick;
        checks++;
        if ({tx_valid, busy, done_p, abort_p, pending, tx_sel, tx_id} !== '0) begin
            errors++;
            $display("FAIL reset_mid_frame: got valid=%b busy=%b done=%b abort=%b pend=%b sel=%0d id=%h, want all 0",
                     tx_valid, busy, done_p, abort_p, pending, tx_sel, tx_id);
        end
        rst = 1'b0;
        result(1'b1, 1'b0, 1'b0);
        checks++;
        if (done_p !== 4'b0000) begin
            errors++;
            $display("FAIL done_outside_active: got done=%b, want 0000", done_p);
        end
        send_req(4'b0001);
        wait_valid(300, n, found);
        accept;
        result(1'b1, 1'b1, 1'b0);
        checks++;
        if (done_p !== 4'b0001 || abort_p !== 4'b0000 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL done_err_same: got done=%b abort=%b pend=%b, want 0001 0000 0000", done_p, abort_p, pending);
        end
        send_req(4'b0001);
        wait_valid(300, n, found);
        accept;
        req = 4'b0001;
        result(1'b1, 1'b0, 1'b0);
        req = '0;
        checks++;
        if (pending !== 4'b0001 || done_p !== 4'b0001) begin
            errors++;
            $display("FAIL req_with_done: got pend=%b done=%b, want 0001 0001", pending, done_p);
        end
        wait_valid(300, n, found);
        checks++;
        if (!found || n !== 112) begin
            errors++;
            $display("FAIL req_with_done_reoffer: got found=%0d cycles=%0d, want 112", found, n);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_priority;
        test_idle_gating;
        test_lost;
        test_err_retry;
        test_coincidence;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
Transmit-side controller for the CAN bit-serial datapath. It holds transmit requests from NUM_MB mailboxes and waits for bus idle. It then grants the transmitter to the pending mailbox with the highest CAN priority (lowest identifier) and sequences the transmitter through a valid/ready handshake. It resolves the result: success, lost arbitration or error, with bounded retry. It sits between the mailbox registers and the bit-level CAN transmitter, and monitors the same serial bus line as the receiver.

Parameters:
NUM_MB, 4, number of mailboxes (2..8)
SEL_W, 2, width of mailbox index; must be at least clog2(NUM_MB)
CLKS_PER_BIT, 10, i_Clock cycles per CAN bit
IDLE_BITS, 11, consecutive recessive bits that define bus idle
RETRY_MAX, 3, error retries per frame before abort (1..15)

Ports:
i_Clock  in  1  single clock; all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
i_Req  in  NUM_MB  one-cycle pulse per mailbox; sets that mailbox pending
i_Id  in  NUM_MB*11  packed 11-bit identifiers; mailbox k at [k*11 +: 11]; must be stable while pending
i_Rx_Serial  in  1  raw CAN bus level; 1 = recessive
o_Tx_Valid  out  1  frame offer to transmitter
i_Tx_Ready  in  1  transmitter accepts offer
o_Tx_Sel  out  SEL_W  granted mailbox index; valid while o_Busy
o_Tx_Id  out  11  granted identifier, registered
i_Tx_Done  in  1  pulse: frame sent and acknowledged
i_Tx_Lost  in  1  pulse: arbitration lost
i_Tx_Err  in  1  pulse: bit/ack/stuff error
o_Pending  out  NUM_MB  current pending mask
o_Done  out  NUM_MB  one-cycle pulse per mailbox on success
o_Abort  out  NUM_MB  one-cycle pulse per mailbox on retry exhaustion
o_Busy  out  1  high in OFFER and ACTIVE

Behaviour:
- Bus sampling: i_Rx_Serial passes through a 2-flop synchronizer. The idle counter increments on each synchronized 1 and clears to 0 on any synchronized 0. It saturates at IDLE_BITS*CLKS_PER_BIT. Idle means counter == IDLE_BITS*CLKS_PER_BIT.
- Reset: state IDLE_WAIT. Idle counter, pending, all retry counters, o_Tx_Sel and o_Tx_Id are 0. o_Tx_Valid, o_Done, o_Abort and o_Busy are 0. Reset mid-frame drops the grant with no o_Done/o_Abort pulse.
- IDLE_WAIT: when idle and pending != 0, go to SELECT on the next cycle. Otherwise stay.
- SELECT (1 cycle): choose the pending mailbox with the numerically lowest i_Id; ties go to the lowest index. Register o_Tx_Sel and o_Tx_Id, then go to OFFER. o_Tx_Valid rises 2 cycles after idle is first reached.
- OFFER: o_Tx_Valid = 1 and the grant is frozen. On i_Tx_Ready = 1, drop o_Tx_Valid on the next cycle and go to ACTIVE.
- ACTIVE: wait for a result pulse. Priority when pulses coincide: Done > Err > Lost.
  - Done: clear pending[sel], clear retry[sel], pulse o_Done[sel].
  - Err: retry[sel] += 1. If the new value equals RETRY_MAX, clear pending[sel], clear retry[sel] and pulse o_Abort[sel]. Otherwise pending is kept.
  - Lost: pending and retry are unchanged; the frame retries with no limit.
  - All three results return to IDLE_WAIT with the idle counter cleared.
- Result pulses outside ACTIVE are ignored. i_Tx_Ready outside OFFER is ignored.
- Simultaneous i_Req[k] and Done/Abort of k in the same cycle: set wins, pending[k] stays 1 and retry[k] clears to 0.
- i_Req on a mailbox already pending has no effect, except that retry[k] clears to 0.
- o_Busy = 1 exactly in OFFER and ACTIVE.
- Priority is re-evaluated only in SELECT. New requests never preempt an OFFER or ACTIVE grant.

Test Plan:
- Single request, bus held at 1: reset, then i_Req=0001 with Id0=0x123. o_Tx_Valid rises 2 cycles after 110 idle clocks; Sel=0, Id=0x123. Ready, then Done: o_Done=0001 for one pulse, pending=0000, Busy=0.
- Priority: Req=1110 with Id1=0x200, Id2=0x050, Id3=0x050 → Sel=2, Id=0x050. After Done → Sel=3. After Done → Sel=1.
- Idle gating: pending set, bus driven 0 once at idle count 100 → no Valid until 110 further consecutive 1-samples.
- Lost arbitration: 5 successive Lost results on mailbox 0 → no o_Abort, pending stays 1, retry=0. Then Done → o_Done[0].
- Error retry: RETRY_MAX=3, three Err results on mailbox 1 → o_Abort=0010 on the third, pending[1]=0. The 2nd Err yields no abort and causes a re-offer.
- Reset and coincidence: i_Reset during ACTIVE → all outputs 0 and no Done pulse. Done and Err in the same cycle → o_Done only. Req[0] with Done of mailbox 0 → pending[0] stays 1.
